// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Brief    : Shared types and constants for the RW0 SRAM port controllers.
// Revision : 1.0
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int RESP_DEPTH = 2;

    localparam int c_req_addr_w = 9;
    localparam int c_req_data_w = 64;
    localparam int c_req_mask_w = 8;

    typedef struct packed {
        logic                    write;
        logic [c_req_addr_w-1:0] addr;
        logic [c_req_data_w-1:0] wdata;
        logic [c_req_mask_w-1:0] wmask;
    } req_t;

    // A new read may issue only if every response it could join still fits.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       pop);
        return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_resp_fifo
// Brief    : Two-entry in-order read-response buffer with occupancy output.
// Revision : 1.0
// ============================================================================
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] r_mem [RESP_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic              w_pop;

    assign w_pop = pop && (r_occ != 2'd0);
    assign occ   = r_occ;
    assign head  = r_mem[r_rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            // At full occupancy a simultaneous pop frees the slot being written.
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, push} - {1'b0, w_pop};
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && !w_pop && (r_occ == 2'd2)))
                else $error("sram_resp_fifo: push into full buffer");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sram_rw_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw_port_ctrl
// Brief    : Request/response front end for a one-cycle-latency RW0 SRAM macro.
// Revision : 1.0
// ============================================================================
module sram_rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W        = 9,
    parameter int DEPTH         = 512,
    parameter int DATA_W        = 64,
    parameter int MASK_W        = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam logic [ADDR_W-1:0] c_ic_last = ADDR_W'(DEPTH - 1);
    localparam logic              c_sweep   = (INIT_ON_RESET != 0);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_ic;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_addr_q;
    logic [MASK_W-1:0] r_wmask_q;
    logic [DATA_W-1:0] r_wdata_q;

    logic [1:0]        w_occ;
    logic              w_pop;
    logic              w_fire;
    logic              w_init_wr;

    assign resp_valid = (w_occ != 2'd0);
    assign w_pop      = resp_valid && resp_ready;
    assign req_ready  = (r_state == RUN) && credit_ok(w_occ, r_inflight, w_pop);
    assign w_fire     = req_valid && req_ready;
    assign init_done  = (r_state == RUN);
    // Reset is folded in so the macro port stays quiet while reset is held.
    assign w_init_wr  = c_sweep && (r_state == INIT) && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        RW0_en      = 1'b0;
        RW0_wmode   = 1'b0;
        RW0_addr    = r_addr_q;
        RW0_wmask   = r_wmask_q;
        RW0_wdata   = r_wdata_q;
        case (r_state)
            INIT: begin
                if (!c_sweep) begin
                    w_state_nxt = RUN;
                end else if (w_init_wr) begin
                    RW0_en    = 1'b1;
                    RW0_wmode = 1'b1;
                    RW0_addr  = r_ic;
                    RW0_wmask = '1;
                    RW0_wdata = '0;
                    if (r_ic == c_ic_last) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (w_fire) begin
                    RW0_en    = 1'b1;
                    RW0_wmode = req_write;
                    RW0_addr  = req_addr;
                    RW0_wmask = req_wmask;
                    RW0_wdata = req_wdata;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ic       <= '0;
            r_inflight <= 1'b0;
            r_addr_q   <= '0;
            r_wmask_q  <= '0;
            r_wdata_q  <= '0;
        end else begin
            if (w_init_wr) begin
                r_ic <= r_ic + ADDR_W'(1);
            end
            // Macro rdata is only meaningful in the cycle right after a read issue.
            r_inflight <= w_fire && !req_write;
            if (RW0_en) begin
                r_addr_q  <= RW0_addr;
                r_wmask_q <= RW0_wmask;
                r_wdata_q <= RW0_wdata;
            end
        end
    end

    sram_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (RW0_rdata),
        .pop       (w_pop),
        .occ       (w_occ),
        .head      (resp_rdata)
    );

endmodule
`default_nettype wire
